hazard_ctrl_unit: RTL and testbench

//  Pipeline controller that sequences the ID/EX -> EX -> MEM datapath: detects load-use hazards, stalls PC and IF/ID,

---
 rtl/hazard_ctrl_unit_if.sv | 49 ++++
 rtl/hazard_ctrl_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-to-hazard-unit bundle: register ids and control bits in,
// stall/flush/forwarding controls and perf counters out.
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_memread,
    output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output branch_taken,
    input  pc_write, if_id_write, id_ex_bubble,
    input  flush_if_id, flush_id_ex, flush_ex_mem,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_memread,
    input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  branch_taken,
    output pc_write, if_id_write, id_ex_bubble,
    output flush_if_id, flush_id_ex, flush_ex_mem,
    output fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: load-use stall, branch flush, ALU forwarding, counters.
// Ports: clk, reset (async active-low), hz (slave side of the pipeline bundle).
module hazard_ctrl_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              reset,
  hazard_ctrl_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] S_RELOAD = 3'(STALL_CYCLES - 1);
  localparam logic [2:0] F_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [2:0]       cnt, cnt_n;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             load_use;
  logic             stall_inc, flush_inc;
  logic             pw, iw, bub, fl;
  logic [1:0]       fa, fb;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mw,
    input logic [4:0] mrd,
    input logic       ww,
    input logic [4:0] wrd
  );
    logic [1:0] s;
    s = 2'b00;
    if (mw && mrd != 5'd0 && mrd == rs)
      s = 2'b10;
    else if (ww && wrd != 5'd0 && wrd == rs)
      s = 2'b01;
    return s;
  endfunction

  assign load_use = hz.ex_memread && hz.ex_rd != 5'd0 &&
    ((hz.id_use_rs1 && hz.ex_rd == hz.id_rs1) ||
     (hz.id_use_rs2 && hz.ex_rd == hz.id_rs2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      cnt       <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + ONE;
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + ONE;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pw        = 1'b1;
    iw        = 1'b1;
    bub       = 1'b0;
    fl        = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (hz.branch_taken) begin
      // taken branch overrides any stall and (re)starts the flush window
      fl        = 1'b1;
      flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        cnt_n   = F_RELOAD;
      end else begin
        state_n = RUN;
        cnt_n   = 3'd0;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            pw        = 1'b0;
            iw        = 1'b0;
            bub       = 1'b1;
            stall_inc = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_n = STALL;
              cnt_n   = S_RELOAD;
            end
          end
        end
        STALL: begin
          pw        = 1'b0;
          iw        = 1'b0;
          bub       = 1'b1;
          stall_inc = 1'b1;
          cnt_n     = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_n = RUN;
            cnt_n   = 3'd0;
          end
        end
        FLUSH: begin
          fl    = 1'b1;
          cnt_n = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_n = RUN;
            cnt_n   = 3'd0;
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    fa = fwd_sel(hz.ex_rs1, hz.mem_regwrite, hz.mem_rd,
                 hz.wb_regwrite, hz.wb_rd);
    fb = fwd_sel(hz.ex_rs2, hz.mem_regwrite, hz.mem_rd,
                 hz.wb_regwrite, hz.wb_rd);
    hz.pc_write     = pw;
    hz.if_id_write  = iw;
    hz.id_ex_bubble = bub;
    hz.flush_if_id  = fl;
    hz.flush_id_ex  = fl;
    hz.flush_ex_mem = fl;
    hz.fwd_a        = fa;
    hz.fwd_b        = fb;
    // outputs fall back to plain pass-through while reset is held
    if (!reset) begin
      hz.pc_write     = 1'b1;
      hz.if_id_write  = 1'b1;
      hz.id_ex_bubble = 1'b0;
      hz.flush_if_id  = 1'b0;
      hz.flush_id_ex  = 1'b0;
      hz.flush_ex_mem = 1'b0;
      hz.fwd_a        = 2'b00;
      hz.fwd_b        = 2'b00;
    end
  end

  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit over four parameter sets.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread;
  logic       mem_regwrite, wb_regwrite, branch_taken;
  bit         done = 1'b0;

  hazard_ctrl_unit_if #(.CNT_W(16)) i0 ();
  hazard_ctrl_unit_if #(.CNT_W(16)) i1 ();
  hazard_ctrl_unit_if #(.CNT_W(16)) i2 ();
  hazard_ctrl_unit_if #(.CNT_W(2))  i3 ();

  assign i0.id_rs1 = id_rs1; assign i0.id_rs2 = id_rs2;
  assign i0.id_use_rs1 = id_use_rs1; assign i0.id_use_rs2 = id_use_rs2;
  assign i0.ex_rs1 = ex_rs1; assign i0.ex_rs2 = ex_rs2;
  assign i0.ex_rd = ex_rd; assign i0.ex_memread = ex_memread;
  assign i0.mem_rd = mem_rd; assign i0.mem_regwrite = mem_regwrite;
  assign i0.wb_rd = wb_rd; assign i0.wb_regwrite = wb_regwrite;
  assign i0.branch_taken = branch_taken;

  assign i1.id_rs1 = id_rs1; assign i1.id_rs2 = id_rs2;
  assign i1.id_use_rs1 = id_use_rs1; assign i1.id_use_rs2 = id_use_rs2;
  assign i1.ex_rs1 = ex_rs1; assign i1.ex_rs2 = ex_rs2;
  assign i1.ex_rd = ex_rd; assign i1.ex_memread = ex_memread;
  assign i1.mem_rd = mem_rd; assign i1.mem_regwrite = mem_regwrite;
  assign i1.wb_rd = wb_rd; assign i1.wb_regwrite = wb_regwrite;
  assign i1.branch_taken = branch_taken;

  assign i2.id_rs1 = id_rs1; assign i2.id_rs2 = id_rs2;
  assign i2.id_use_rs1 = id_use_rs1; assign i2.id_use_rs2 = id_use_rs2;
  assign i2.ex_rs1 = ex_rs1; assign i2.ex_rs2 = ex_rs2;
  assign i2.ex_rd = ex_rd; assign i2.ex_memread = ex_memread;
  assign i2.mem_rd = mem_rd; assign i2.mem_regwrite = mem_regwrite;
  assign i2.wb_rd = wb_rd; assign i2.wb_regwrite = wb_regwrite;
  assign i2.branch_taken = branch_taken;

  assign i3.id_rs1 = id_rs1; assign i3.id_rs2 = id_rs2;
  assign i3.id_use_rs1 = id_use_rs1; assign i3.id_use_rs2 = id_use_rs2;
  assign i3.ex_rs1 = ex_rs1; assign i3.ex_rs2 = ex_rs2;
  assign i3.ex_rd = ex_rd; assign i3.ex_memread = ex_memread;
  assign i3.mem_rd = mem_rd; assign i3.mem_regwrite = mem_regwrite;
  assign i3.wb_rd = wb_rd; assign i3.wb_regwrite = wb_regwrite;
  assign i3.branch_taken = branch_taken;

  hazard_ctrl_unit #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16))
    d0 (.clk(clk), .reset(reset), .hz(i0.slave));
  hazard_ctrl_unit #(.STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(16))
    d1 (.clk(clk), .reset(reset), .hz(i1.slave));
  hazard_ctrl_unit #(.STALL_CYCLES(1), .FLUSH_CYCLES(4), .CNT_W(16))
    d2 (.clk(clk), .reset(reset), .hz(i2.slave));
  hazard_ctrl_unit #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(2))
    d3 (.clk(clk), .reset(reset), .hz(i3.slave));

  typedef logic [41:0] vec_t;
  vec_t obs [4];

  assign obs[0] = {i0.pc_write, i0.if_id_write, i0.id_ex_bubble,
    i0.flush_if_id, i0.flush_id_ex, i0.flush_ex_mem,
    i0.fwd_a, i0.fwd_b, i0.stall_cnt, i0.flush_cnt};
  assign obs[1] = {i1.pc_write, i1.if_id_write, i1.id_ex_bubble,
    i1.flush_if_id, i1.flush_id_ex, i1.flush_ex_mem,
    i1.fwd_a, i1.fwd_b, i1.stall_cnt, i1.flush_cnt};
  assign obs[2] = {i2.pc_write, i2.if_id_write, i2.id_ex_bubble,
    i2.flush_if_id, i2.flush_id_ex, i2.flush_ex_mem,
    i2.fwd_a, i2.fwd_b, i2.stall_cnt, i2.flush_cnt};
  assign obs[3] = {i3.pc_write, i3.if_id_write, i3.id_ex_bubble,
    i3.flush_if_id, i3.flush_id_ex, i3.flush_ex_mem,
    i3.fwd_a, i3.fwd_b, 14'd0, i3.stall_cnt, 14'd0, i3.flush_cnt};

  typedef struct {
    int    dut;
    string name;
    vec_t  exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t pk(bit pw, bit iw, bit bub, logic [2:0] fl,
                              logic [1:0] fa, logic [1:0] fb,
                              int sc, int fc);
    return {pw, iw, bub, fl, fa, fb, 16'(sc), 16'(fc)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (obs[e.dut] !== e.exp) begin
        n_bad++;
        $display("FAIL %s dut%0d got %h want %h",
                 e.name, e.dut, obs[e.dut], e.exp);
      end
    end
  end

  initial begin
    fork
      wait (done);
      repeat (2000) @(posedge clk);
    join_any
    if (!done) begin
      n_bad++;
      $display("FAIL watchdog expired before test end");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
    end
  end

  task automatic push(input int dut, input string name, input vec_t exp);
    exp_t e;
    e.dut  = dut;
    e.name = name;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int dut, input string name, input vec_t exp);
    push(dut, name, exp);
    tick();
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    branch_taken = 0;
  endtask

  task automatic lu();
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    tick();
    reset = 1;
  endtask

  initial begin
    reset = 0;
    idle();
    tick();
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (obs[d] !== pk(1, 1, 0, 0, 0, 0, 0, 0)) begin
        n_bad++;
        $display("FAIL rst_state dut%0d got %h", d, obs[d]);
      end
    end
    lu();
    mem_rd = 7; mem_regwrite = 1; ex_rs1 = 7;
    push(3, "rst_forced3", pk(1, 1, 0, 0, 0, 0, 0, 0));
    chk(0, "rst_forced", pk(1, 1, 0, 0, 0, 0, 0, 0));
    reset = 1;
    idle();

    lu();
    chk(0, "lu_stall", pk(0, 0, 1, 0, 0, 0, 0, 0));
    idle();
    chk(0, "lu_done", pk(1, 1, 0, 0, 0, 0, 1, 0));

    do_reset();
    lu();
    chk(1, "s3_c1", pk(0, 0, 1, 0, 0, 0, 0, 0));
    idle();
    chk(1, "s3_c2", pk(0, 0, 1, 0, 0, 0, 1, 0));
    chk(1, "s3_c3", pk(0, 0, 1, 0, 0, 0, 2, 0));
    chk(1, "s3_run", pk(1, 1, 0, 0, 0, 0, 3, 0));

    do_reset();
    lu();
    chk(1, "ab_stall", pk(0, 0, 1, 0, 0, 0, 0, 0));
    idle();
    branch_taken = 1;
    chk(1, "ab_flush", pk(1, 1, 0, 7, 0, 0, 1, 0));
    idle();
    chk(1, "ab_run", pk(1, 1, 0, 0, 0, 0, 1, 1));

    do_reset();
    lu();
    branch_taken = 1;
    chk(0, "br_lu", pk(1, 1, 0, 7, 0, 0, 0, 0));
    idle();
    chk(0, "br_done", pk(1, 1, 0, 0, 0, 0, 0, 1));

    do_reset();
    mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1;
    ex_rs1 = 7; ex_rs2 = 0;
    chk(0, "fwd_mem", pk(1, 1, 0, 0, 2, 0, 0, 0));
    mem_regwrite = 0;
    chk(0, "fwd_wb", pk(1, 1, 0, 0, 1, 0, 0, 0));
    ex_rs2 = 7;
    chk(0, "fwd_wb_b", pk(1, 1, 0, 0, 1, 1, 0, 0));
    mem_regwrite = 1; ex_rs2 = 3;
    chk(0, "fwd_mix", pk(1, 1, 0, 0, 2, 0, 0, 0));
    mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    chk(0, "fwd_x0", pk(1, 1, 0, 0, 0, 0, 0, 0));

    do_reset();
    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    chk(0, "x0_nostall", pk(1, 1, 0, 0, 0, 0, 0, 0));
    idle();
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 0;
    chk(0, "rs2_unused", pk(1, 1, 0, 0, 0, 0, 0, 0));
    id_use_rs2 = 1;
    chk(0, "rs2_stall", pk(0, 0, 1, 0, 0, 0, 0, 0));
    idle();
    chk(0, "rs2_done", pk(1, 1, 0, 0, 0, 0, 1, 0));

    do_reset();
    branch_taken = 1;
    chk(2, "f4_c1", pk(1, 1, 0, 7, 0, 0, 0, 0));
    idle();
    lu();
    chk(2, "f4_nolu", pk(1, 1, 0, 7, 0, 0, 0, 1));
    reset = 0;
    chk(2, "f4_rst", pk(1, 1, 0, 0, 0, 0, 0, 0));
    idle();
    reset = 1;
    chk(2, "f4_after", pk(1, 1, 0, 0, 0, 0, 0, 0));

    do_reset();
    branch_taken = 1;
    chk(2, "fr_c1", pk(1, 1, 0, 7, 0, 0, 0, 0));
    chk(2, "fr_c2", pk(1, 1, 0, 7, 0, 0, 0, 1));
    idle();
    chk(2, "fr_c3", pk(1, 1, 0, 7, 0, 0, 0, 2));
    chk(2, "fr_c4", pk(1, 1, 0, 7, 0, 0, 0, 2));
    chk(2, "fr_c5", pk(1, 1, 0, 7, 0, 0, 0, 2));
    chk(2, "fr_run", pk(1, 1, 0, 0, 0, 0, 0, 2));

    do_reset();
    lu();
    for (int i = 0; i < 5; i++)
      chk(3, $sformatf("sat_%0d", i),
          pk(0, 0, 1, 0, 0, 0, (i > 3) ? 3 : i, 0));
    idle();
    chk(3, "sat_hold", pk(1, 1, 0, 0, 0, 0, 3, 0));

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
